crossbar_out_arbiter: RTL and testbench

- Output-side stage of the crossbar, one instance per egress port.
- Collects transmit requests from the P_PORT_NUM crossbar points targeting this egress port, grants one at a time by round-robin, and muxes the granted point's AXI-Stream packet onto the single egress stream.
- Holds the grant until the packet's tlast handshake completes, then re-arbitrates.
- Includes a watchdog so a granted point that never sends data cannot stall the port.

---
 rtl/crossbar_out_arbiter.sv | 182 ++++++++++++++++++
 tb/tb_crossbar_out_arbiter.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/crossbar_out_arbiter.sv
// -----------------------------------------------------------------------------
// crossbar_out_arbiter
//
// Egress-side stage of the crossbar, one instance per egress port. Collects
// transmit requests from the crossbar points that target this port, grants
// one point at a time in round-robin order, and multiplexes the granted
// point's AXI-Stream packet onto the single egress stream. The grant is held
// until the packet's tlast handshake. A watchdog abandons a grant whose
// owner never presents data.
//
// Ports:
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_trans_req[N]           per-point transmit request (level)
//   o_trans_grant[N]         one-hot, single-cycle grant pulse
//   s_axis_*                 per-point AXI-Stream slaves (64-bit data, 8-bit keep)
//   m_axis_*                 egress AXI-Stream master
//   o_busy                   high whenever a grant is in progress
//   o_timeout                one-cycle pulse when the watchdog fires
// -----------------------------------------------------------------------------
module crossbar_out_arbiter #(
    parameter int          P_PORT_NUM = 4,
    parameter logic [15:0] P_TIMEOUT  = 16'd1024
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic [P_PORT_NUM-1:0]   i_trans_req,
    output logic [P_PORT_NUM-1:0]   o_trans_grant,
    input  logic [P_PORT_NUM-1:0]   s_axis_tvalid,
    input  logic [64*P_PORT_NUM-1:0] s_axis_tdata,
    input  logic [P_PORT_NUM-1:0]   s_axis_tlast,
    input  logic [8*P_PORT_NUM-1:0] s_axis_tkeep,
    input  logic [P_PORT_NUM-1:0]   s_axis_tuser,
    output logic [P_PORT_NUM-1:0]   s_axis_tready,
    output logic                    m_axis_tvalid,
    output logic [63:0]             m_axis_tdata,
    output logic                    m_axis_tlast,
    output logic [7:0]              m_axis_tkeep,
    output logic                    m_axis_tuser,
    input  logic                    m_axis_tready,
    output logic                    o_busy,
    output logic                    o_timeout
);

    localparam int SEL_W = (P_PORT_NUM > 1) ? $clog2(P_PORT_NUM) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_WAIT_VALID,
        ST_TRANS
    } state_t;

    state_t                  state_reg;
    logic [SEL_W-1:0]        rr_ptr_reg;
    logic [SEL_W-1:0]        sel_reg;
    logic [15:0]             wd_cnt_reg;
    logic [P_PORT_NUM-1:0]   grant_reg;
    logic                    timeout_reg;

    // Per-point slices of the flattened slave buses.
    logic [63:0]             tdata_arr [P_PORT_NUM];
    logic [7:0]              tkeep_arr [P_PORT_NUM];

    logic                    path_open;
    logic                    sel_valid;
    logic                    sel_last;
    logic                    last_beat_done;
    logic                    any_req;
    logic [SEL_W-1:0]        rr_pick;
    logic [SEL_W:0]          rr_idx;

    // Wrap-around increment of a point index.
    function automatic logic [SEL_W-1:0] ptr_inc(input logic [SEL_W-1:0] p);
        return (p == SEL_W'(P_PORT_NUM - 1)) ? '0 : p + SEL_W'(1);
    endfunction

    // -------------------------------------------------------------------------
    // Datapath: purely combinational mux from the selected point. The path is
    // only open while a grant is active, so every egress output is 0 otherwise.
    // -------------------------------------------------------------------------
    assign path_open = (state_reg == ST_WAIT_VALID) || (state_reg == ST_TRANS);
    assign sel_valid = s_axis_tvalid[sel_reg];
    assign sel_last  = s_axis_tlast[sel_reg];

    genvar gi;
    generate
        for (gi = 0; gi < P_PORT_NUM; gi++) begin : g_point
            assign tdata_arr[gi]     = s_axis_tdata[64*gi +: 64];
            assign tkeep_arr[gi]     = s_axis_tkeep[8*gi +: 8];
            assign s_axis_tready[gi] = path_open && (sel_reg == SEL_W'(gi)) && m_axis_tready;
        end
    endgenerate

    assign m_axis_tvalid = path_open & sel_valid;
    assign m_axis_tdata  = path_open ? tdata_arr[sel_reg] : 64'd0;
    assign m_axis_tkeep  = path_open ? tkeep_arr[sel_reg] : 8'd0;
    assign m_axis_tlast  = path_open & sel_last;
    assign m_axis_tuser  = path_open & s_axis_tuser[sel_reg];

    assign last_beat_done = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    // -------------------------------------------------------------------------
    // Round-robin pick: scan rr_ptr, rr_ptr+1, ... (mod N). Iterating from the
    // farthest offset down lets the nearest requester overwrite the result.
    // -------------------------------------------------------------------------
    always_comb begin
        any_req = |i_trans_req;
        rr_pick = rr_ptr_reg;
        rr_idx  = '0;
        for (int i = P_PORT_NUM - 1; i >= 0; i--) begin
            rr_idx = {1'b0, rr_ptr_reg} + (SEL_W+1)'(i);
            if (rr_idx >= (SEL_W+1)'(P_PORT_NUM)) begin
                rr_idx = rr_idx - (SEL_W+1)'(P_PORT_NUM);
            end
            if (i_trans_req[rr_idx]) begin
                rr_pick = rr_idx[SEL_W-1:0];
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control FSM with registered grant / timeout pulses.
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg   <= ST_IDLE;
            rr_ptr_reg  <= '0;
            sel_reg     <= '0;
            wd_cnt_reg  <= '0;
            grant_reg   <= '0;
            timeout_reg <= 1'b0;
        end else begin
            grant_reg   <= '0;
            timeout_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (any_req) begin
                        sel_reg   <= rr_pick;
                        grant_reg <= P_PORT_NUM'(1) << rr_pick;
                        state_reg <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    wd_cnt_reg <= '0;
                    state_reg  <= ST_WAIT_VALID;
                end
                ST_WAIT_VALID: begin
                    if (sel_valid) begin
                        // The path is already open here, so a single-beat
                        // packet can complete on this very cycle; finishing
                        // directly avoids waiting in TRANS for a tlast that
                        // has already gone by.
                        if (last_beat_done) begin
                            rr_ptr_reg <= ptr_inc(sel_reg);
                            state_reg  <= ST_IDLE;
                        end else begin
                            state_reg  <= ST_TRANS;
                        end
                    end else if (wd_cnt_reg == P_TIMEOUT - 16'd1) begin
                        timeout_reg <= 1'b1;
                        rr_ptr_reg  <= ptr_inc(sel_reg);
                        state_reg   <= ST_IDLE;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + 16'd1;
                    end
                end
                ST_TRANS: begin
                    if (last_beat_done) begin
                        rr_ptr_reg <= ptr_inc(sel_reg);
                        state_reg  <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign o_trans_grant = grant_reg;
    assign o_timeout     = timeout_reg;
    assign o_busy        = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_crossbar_out_arbiter.sv
// -----------------------------------------------------------------------------
// Directed testbench for crossbar_out_arbiter (4 points, watchdog of 16).
// Inputs are driven 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// -----------------------------------------------------------------------------
module tb_crossbar_out_arbiter;

    localparam int          N  = 4;
    localparam logic [15:0] TO = 16'd16;

    logic               i_clk = 1'b0;
    logic               i_rst_n;
    logic [N-1:0]       req;
    logic [N-1:0]       grant;
    logic [N-1:0]       tvalid;
    logic [64*N-1:0]    tdata;
    logic [N-1:0]       tlast;
    logic [8*N-1:0]     tkeep;
    logic [N-1:0]       tuser;
    logic [N-1:0]       tready_s;
    logic               m_tvalid;
    logic [63:0]        m_tdata;
    logic               m_tlast;
    logic [7:0]         m_tkeep;
    logic               m_tuser;
    logic               m_tready;
    logic               busy;
    logic               tout;

    int checks = 0;
    int errors = 0;

    logic [63:0] cap_data [16];
    logic [7:0]  cap_keep [16];
    logic        cap_last [16];
    logic        cap_user [16];

    crossbar_out_arbiter #(
        .P_PORT_NUM (N),
        .P_TIMEOUT  (TO)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_trans_req   (req),
        .o_trans_grant (grant),
        .s_axis_tvalid (tvalid),
        .s_axis_tdata  (tdata),
        .s_axis_tlast  (tlast),
        .s_axis_tkeep  (tkeep),
        .s_axis_tuser  (tuser),
        .s_axis_tready (tready_s),
        .m_axis_tvalid (m_tvalid),
        .m_axis_tdata  (m_tdata),
        .m_axis_tlast  (m_tlast),
        .m_axis_tkeep  (m_tkeep),
        .m_axis_tuser  (m_tuser),
        .m_axis_tready (m_tready),
        .o_busy        (busy),
        .o_timeout     (tout)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic [63:0] beat_data(input int pt, input int b);
        return {8'hA5, pt[7:0], 16'h5A00, b[31:0]};
    endfunction

    task automatic clear_inputs();
        req      = '0;
        tvalid   = '0;
        tdata    = '0;
        tlast    = '0;
        tkeep    = '0;
        tuser    = '0;
        m_tready = 1'b1;
    endtask

    task automatic apply_reset();
        clear_inputs();
        i_rst_n = 1'b0;
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
    endtask

    // Waits for a grant pulse; lat is the number of falling edges seen before
    // the pulse (-1 if none). Returns 1 unit after the edge ending GRANT.
    task automatic wait_grant(output int lat, output logic [N-1:0] g);
        lat = -1;
        g   = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge i_clk);
            if (grant !== '0) begin
                lat = n;
                g   = grant;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        if (lat >= 0) begin
            @(posedge i_clk);
            #1;
        end
        $display("grant: lat=%0d grant=%b", lat, g);
    endtask

    // Acts as point pt sending an nbeats packet, advancing on its own tready.
    // Captures every egress handshake and counts tready misbehaviour.
    task automatic send_packet(input int pt, input int nbeats, input logic [7:0] last_keep,
                               input bit rand_ready, output int nout, output int tready_bad,
                               output int grant_seen, output bit hung);
        int           b;
        bit           adv;
        logic [N-1:0] other;
        b          = 0;
        nout       = 0;
        tready_bad = 0;
        grant_seen = 0;
        hung       = 1'b1;
        other      = ~(N'(1) << pt);
        for (int i = 0; i < 16; i++) begin
            cap_data[i] = 'x;
            cap_keep[i] = 'x;
            cap_last[i] = 1'bx;
            cap_user[i] = 1'bx;
        end
        for (int c = 0; c < 200; c++) begin
            tvalid[pt]          = 1'b1;
            tdata[64*pt +: 64]  = beat_data(pt, b);
            tlast[pt]           = (b == nbeats - 1);
            tkeep[8*pt +: 8]    = (b == nbeats - 1) ? last_keep : 8'hFF;
            tuser[pt]           = (b == 0);
            m_tready            = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            @(negedge i_clk);
            if (grant !== '0) grant_seen++;
            if (tready_s[pt] !== m_tready) tready_bad++;
            if ((tready_s & other) !== '0) tready_bad++;
            if (m_tvalid === 1'b1 && m_tready && nout < 16) begin
                cap_data[nout] = m_tdata;
                cap_keep[nout] = m_tkeep;
                cap_last[nout] = m_tlast;
                cap_user[nout] = m_tuser;
                nout++;
            end
            adv = (tready_s[pt] === 1'b1);
            @(posedge i_clk);
            #1;
            if (adv) b++;
            if (b == nbeats) begin
                hung = 1'b0;
                break;
            end
        end
        tvalid[pt] = 1'b0;
        tlast[pt]  = 1'b0;
        tuser[pt]  = 1'b0;
        m_tready   = 1'b1;
        $display("packet: point=%0d beats=%0d egress=%0d hung=%0d", pt, nbeats, nout, hung);
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        clear_inputs();
        tvalid  = '1;
        tdata   = '1;
        tkeep   = '1;
        i_rst_n = 1'b0;
        @(negedge i_clk);
        checks++;
        if ({grant, tready_s, m_tvalid, m_tlast, m_tuser, busy, tout} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl: got grant=%b tready=%b tvalid=%b busy=%b timeout=%b, expected all 0",
                     grant, tready_s, m_tvalid, busy, tout);
        end
        checks++;
        if (m_tdata !== 64'd0 || m_tkeep !== 8'd0) begin
            errors++;
            $display("FAIL reset_data: got tdata=%h tkeep=%h, expected 0", m_tdata, m_tkeep);
        end
        @(posedge i_clk);
        #1;
        clear_inputs();
        i_rst_n = 1'b1;
    endtask

    task automatic test_single();
        int lat, nout, tb, gs;
        logic [N-1:0] g;
        bit hung;
        req[2] = 1'b1;
        wait_grant(lat, g);
        req[2] = 1'b0;
        checks++;
        if (lat !== 1) begin
            errors++;
            $display("FAIL single_grant_lat: got %0d expected 1", lat);
        end
        checks++;
        if (g !== 4'b0100) begin
            errors++;
            $display("FAIL single_grant: got %b expected 0100", g);
        end
        send_packet(2, 4, 8'h0F, 1'b0, nout, tb, gs, hung);
        checks++;
        if (nout !== 4 || hung) begin
            errors++;
            $display("FAIL single_beats: got %0d (hung=%0d) expected 4", nout, hung);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (cap_data[i] !== beat_data(2, i) || cap_keep[i] !== ((i == 3) ? 8'h0F : 8'hFF) ||
                cap_last[i] !== (i == 3) || cap_user[i] !== (i == 0)) begin
                errors++;
                $display("FAIL single_beat%0d: got data=%h keep=%h last=%b user=%b expected data=%h keep=%h last=%b user=%b",
                         i, cap_data[i], cap_keep[i], cap_last[i], cap_user[i], beat_data(2, i),
                         (i == 3) ? 8'h0F : 8'hFF, (i == 3), (i == 0));
            end
        end
        checks++;
        if (tb !== 0 || gs !== 0) begin
            errors++;
            $display("FAIL single_tready_grant: got tready errors=%0d extra grants=%0d expected 0,0", tb, gs);
        end
        @(negedge i_clk);
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL single_idle: got busy=%b tvalid=%b expected 0,0", busy, m_tvalid);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_round_robin();
        int lat, nout, tb, gs;
        logic [N-1:0] g;
        bit hung;
        apply_reset();
        req = 4'b1011;
        wait_grant(lat, g);
        checks++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL rr_first: got %b expected 0001", g);
        end
        req[0] = 1'b0;
        send_packet(0, 2, 8'hFF, 1'b0, nout, tb, gs, hung);
        wait_grant(lat, g);
        checks++;
        if (g !== 4'b0010 || lat !== 1) begin
            errors++;
            $display("FAIL rr_second: got grant=%b lat=%0d expected 0010 lat=1", g, lat);
        end
        req[1] = 1'b0;
        send_packet(1, 3, 8'hFF, 1'b0, nout, tb, gs, hung);
        checks++;
        if (nout !== 3 || tb !== 0) begin
            errors++;
            $display("FAIL rr_pkt1: got beats=%0d tready errors=%0d expected 3,0", nout, tb);
        end
        req[1] = 1'b1;
        req[0] = 1'b1;
        wait_grant(lat, g);
        checks++;
        if (g !== 4'b1000) begin
            errors++;
            $display("FAIL rr_third: got %b expected 1000", g);
        end
        req[3] = 1'b0;
        send_packet(3, 2, 8'hFF, 1'b0, nout, tb, gs, hung);
        wait_grant(lat, g);
        checks++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL rr_wrap: got %b expected 0001", g);
        end
        req[0] = 1'b0;
        send_packet(0, 1, 8'hFF, 1'b0, nout, tb, gs, hung);
        wait_grant(lat, g);
        checks++;
        if (g !== 4'b0010) begin
            errors++;
            $display("FAIL rr_fifth: got %b expected 0010", g);
        end
        req[1] = 1'b0;
        send_packet(1, 1, 8'hFF, 1'b0, nout, tb, gs, hung);
    endtask

    task automatic test_backpressure();
        int lat, nout, tb, gs;
        logic [N-1:0] g;
        bit hung;
        req[0] = 1'b1;
        wait_grant(lat, g);
        req[0] = 1'b0;
        checks++;
        if (g !== 4'b0001) begin
            errors++;
            $display("FAIL bp_grant: got %b expected 0001", g);
        end
        send_packet(0, 8, 8'h3F, 1'b1, nout, tb, gs, hung);
        checks++;
        if (nout !== 8 || hung) begin
            errors++;
            $display("FAIL bp_beats: got %0d (hung=%0d) expected 8", nout, hung);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (cap_data[i] !== beat_data(0, i) || cap_last[i] !== (i == 7)) begin
                errors++;
                $display("FAIL bp_beat%0d: got data=%h last=%b expected data=%h last=%b",
                         i, cap_data[i], cap_last[i], beat_data(0, i), (i == 7));
            end
        end
        checks++;
        if (tb !== 0) begin
            errors++;
            $display("FAIL bp_tready: got %0d tready errors expected 0", tb);
        end
    endtask

    task automatic test_timeout();
        int lat, nout, tb, gs, tn;
        logic [N-1:0] g;
        logic busy_at_to;
        bit hung;
        apply_reset();
        req = 4'b0110;
        wait_grant(lat, g);
        checks++;
        if (g !== 4'b0010) begin
            errors++;
            $display("FAIL to_grant: got %b expected 0010", g);
        end
        req[1] = 1'b0;
        req[0] = 1'b1;
        tn = -1;
        busy_at_to = 1'bx;
        for (int n = 0; n < 40; n++) begin
            @(negedge i_clk);
            if (tout === 1'b1) begin
                tn = n;
                busy_at_to = busy;
                break;
            end
            @(posedge i_clk);
            #1;
        end
        checks++;
        if (tn !== 16) begin
            errors++;
            $display("FAIL to_cycle: got timeout at %0d expected 16", tn);
        end
        checks++;
        if (busy_at_to !== 1'b0) begin
            errors++;
            $display("FAIL to_idle: got busy=%b expected 0", busy_at_to);
        end
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        checks++;
        if (tout !== 1'b0 || grant !== 4'b0100) begin
            errors++;
            $display("FAIL to_next: got timeout=%b grant=%b expected 0 0100", tout, grant);
        end
        @(posedge i_clk);
        #1;
        req[2] = 1'b0;
        send_packet(2, 2, 8'hFF, 1'b0, nout, tb, gs, hung);
        checks++;
        if (nout !== 2) begin
            errors++;
            $display("FAIL to_pkt: got %0d beats expected 2", nout);
        end
        wait_grant(lat, g);
        req[0] = 1'b0;
        send_packet(0, 1, 8'hFF, 1'b0, nout, tb, gs, hung);
    endtask

    task automatic test_one_beat();
        int lat, nout, tb, gs;
        logic [N-1:0] g;
        bit hung;
        req[3] = 1'b1;
        wait_grant(lat, g);
        req[3] = 1'b0;
        checks++;
        if (g !== 4'b1000) begin
            errors++;
            $display("FAIL one_grant: got %b expected 1000", g);
        end
        send_packet(3, 1, 8'h01, 1'b0, nout, tb, gs, hung);
        checks++;
        if (nout !== 1 || cap_last[0] !== 1'b1 || cap_keep[0] !== 8'h01 || cap_data[0] !== beat_data(3, 0)) begin
            errors++;
            $display("FAIL one_beat: got beats=%0d last=%b keep=%h data=%h expected 1 1 01 %h",
                     nout, cap_last[0], cap_keep[0], cap_data[0], beat_data(3, 0));
        end
        @(negedge i_clk);
        checks++;
        if (busy !== 1'b0 || m_tvalid !== 1'b0) begin
            errors++;
            $display("FAIL one_idle: got busy=%b tvalid=%b expected 0,0", busy, m_tvalid);
        end
        @(posedge i_clk);
        #1;
    endtask

    task automatic test_reset_mid();
        int lat, nout, tb, gs;
        logic [N-1:0] g;
        bit hung;
        req[1] = 1'b1;
        wait_grant(lat, g);
        req[1] = 1'b0;
        checks++;
        if (g !== 4'b0010) begin
            errors++;
            $display("FAIL mid_grant: got %b expected 0010", g);
        end
        m_tready = 1'b1;
        for (int b = 0; b < 3; b++) begin
            tvalid[1]       = 1'b1;
            tdata[64 +: 64] = beat_data(1, b);
            tkeep[8 +: 8]   = 8'hFF;
            tlast[1]        = 1'b0;
            @(negedge i_clk);
            if (b < 2) begin
                @(posedge i_clk);
                #1;
            end
        end
        checks++;
        if (m_tvalid !== 1'b1 || m_tdata !== beat_data(1, 2)) begin
            errors++;
            $display("FAIL mid_beat3: got tvalid=%b data=%h expected 1 %h", m_tvalid, m_tdata, beat_data(1, 2));
        end
        i_rst_n = 1'b0;
        #1;
        checks++;
        if ({m_tvalid, tready_s, busy, grant, tout} !== '0 || m_tdata !== 64'd0) begin
            errors++;
            $display("FAIL mid_reset: got tvalid=%b tready=%b busy=%b grant=%b data=%h expected all 0",
                     m_tvalid, tready_s, busy, grant, m_tdata);
        end
        clear_inputs();
        @(posedge i_clk);
        @(posedge i_clk);
        #1;
        i_rst_n = 1'b1;
        req[0] = 1'b1;
        wait_grant(lat, g);
        req[0] = 1'b0;
        checks++;
        if (g !== 4'b0001 || lat !== 1) begin
            errors++;
            $display("FAIL mid_regrant: got grant=%b lat=%0d expected 0001 lat=1", g, lat);
        end
        send_packet(0, 1, 8'hFF, 1'b0, nout, tb, gs, hung);
        checks++;
        if (nout !== 1 || hung) begin
            errors++;
            $display("FAIL mid_pkt: got %0d beats expected 1", nout);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_one_beat();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
